// File: rtl/coin_pkg.sv
// Shared types and coin constants for the coin payout controller.
package coin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam int unsigned NICKEL_UNITS = 1;
    localparam int unsigned DIME_UNITS   = 2;

    typedef enum logic {
        COIN_NICKEL,
        COIN_DIME
    } coin_t;

endpackage

// File: rtl/coin_payout_if.sv
// Payout request / completion bundle between a vend controller and coin_payout.
interface coin_payout_if #(
    parameter int AMT_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] short_amount;

    modport master (
        output req_valid, req_amount,
        input  req_ready, done, short, short_amount
    );

    modport slave (
        input  req_valid, req_amount,
        output req_ready, done, short, short_amount
    );
endinterface

// File: rtl/coin_inventory.sv
// One coin-tube inventory: saturating up on load, down on take, both at once hold.
module coin_inventory #(
    parameter int INV_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             take,
    output logic [INV_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load && !take) begin
            if (count != '1) count <= count + INV_W'(1);
        end else if (take && !load) begin
            if (count != '0) count <= count - INV_W'(1);
        end
    end

endmodule

// File: rtl/coin_payout.sv
// Coin payout sequencer: pays a nickel amount greedily in dimes then nickels.
// Optional ack watchdog enabled by defining COIN_TIMEOUT_EN.
module coin_payout
    import coin_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int INV_W       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    coin_payout_if.slave     req,
    output logic             dime_eject,
    output logic             nickel_eject,
    input  logic             hopper_ack,
    input  logic             load_dime,
    input  logic             load_nickel,
    output logic [INV_W-1:0] dime_count,
    output logic [INV_W-1:0] nickel_count,
    output logic             fault
);

    // state    | meaning
    // IDLE     | ready for a request
    // SELECT   | pick next coin from remaining amount and inventory
    // EJECT    | pulse the chosen coin's eject line
    // WAIT_ACK | wait for hopper to confirm the coin left
    // DONE     | report completion and any shortfall
    // FAULT    | hopper never answered; held until reset

`ifdef COIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AMT_W-1:0] DIME_AMT   = AMT_W'(DIME_UNITS);
    localparam logic [AMT_W-1:0] NICKEL_AMT = AMT_W'(NICKEL_UNITS);

    state_t           state;
    coin_t            coin;
    logic [AMT_W-1:0] remaining;
    logic [TMR_W-1:0] ack_tmr;
    logic             take_dime;
    logic             take_nickel;

    assign req.req_ready = (state == ST_IDLE);

    assign take_dime   = (state == ST_WAIT_ACK) && hopper_ack && (coin == COIN_DIME);
    assign take_nickel = (state == ST_WAIT_ACK) && hopper_ack && (coin == COIN_NICKEL);

    coin_inventory #(.INV_W(INV_W)) u_dime_inv (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load_dime),
        .take    (take_dime),
        .count   (dime_count)
    );

    coin_inventory #(.INV_W(INV_W)) u_nickel_inv (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load_nickel),
        .take    (take_nickel),
        .count   (nickel_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            coin             <= COIN_NICKEL;
            remaining        <= '0;
            ack_tmr          <= '0;
            dime_eject       <= 1'b0;
            nickel_eject     <= 1'b0;
            req.done         <= 1'b0;
            req.short        <= 1'b0;
            req.short_amount <= '0;
            fault            <= 1'b0;
        end else begin
            dime_eject       <= 1'b0;
            nickel_eject     <= 1'b0;
            req.done         <= 1'b0;
            req.short        <= 1'b0;
            req.short_amount <= '0;

            case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        remaining <= req.req_amount;
                        state     <= ST_SELECT;
                    end
                end

                ST_SELECT: begin
                    if (remaining >= DIME_AMT && dime_count != '0) begin
                        coin  <= COIN_DIME;
                        state <= ST_EJECT;
                    end else if (remaining >= NICKEL_AMT && nickel_count != '0) begin
                        coin  <= COIN_NICKEL;
                        state <= ST_EJECT;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_EJECT: begin
                    dime_eject   <= (coin == COIN_DIME);
                    nickel_eject <= (coin == COIN_NICKEL);
                    ack_tmr      <= TMR_W'(ACK_TIMEOUT - 1);
                    state        <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    // an ack arriving on the last allowed cycle still counts
                    if (hopper_ack) begin
                        remaining <= remaining - ((coin == COIN_DIME) ? DIME_AMT : NICKEL_AMT);
                        state     <= ST_SELECT;
                    end else if (TMO_EN && ack_tmr == '0) begin
                        fault <= 1'b1;
                        state <= ST_FAULT;
                    end else if (TMO_EN) begin
                        ack_tmr <= ack_tmr - TMR_W'(1);
                    end
                end

                ST_DONE: begin
                    req.done         <= 1'b1;
                    req.short        <= (remaining != '0);
                    req.short_amount <= remaining;
                    state            <= ST_IDLE;
                end

                ST_FAULT: begin
                    state <= ST_FAULT;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_payout.sv
// Self-checking bench for coin_payout: directed corner cases plus randomized payouts
// against a greedy dimes-then-nickels reference model.
module tb_coin_payout;

    localparam int AMT_W = 6;
    localparam int INV_W = 8;
    localparam int INV_MAX = 255;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             dime_eject;
    logic             nickel_eject;
    logic             hopper_ack = 1'b0;
    logic             load_dime = 1'b0;
    logic             load_nickel = 1'b0;
    logic [INV_W-1:0] dime_count;
    logic [INV_W-1:0] nickel_count;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;
    int m_dimes  = 0;
    int m_nickels = 0;

    always #5 clock = ~clock;

    coin_payout_if #(.AMT_W(AMT_W)) pif ();

    coin_payout #(
        .AMT_W       (AMT_W),
        .INV_W       (INV_W),
        .ACK_TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (pif.slave),
        .dime_eject   (dime_eject),
        .nickel_eject (nickel_eject),
        .hopper_ack   (hopper_ack),
        .load_dime    (load_dime),
        .load_nickel  (load_nickel),
        .dime_count   (dime_count),
        .nickel_count (nickel_count),
        .fault        (fault)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > INV_MAX) ? INV_MAX : a + b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},   pif.req_ready, 1);
        check_val({tag, "_done"},    pif.done, 0);
        check_val({tag, "_short"},   pif.short, 0);
        check_val({tag, "_shamt"},   pif.short_amount, 0);
        check_val({tag, "_dej"},     dime_eject, 0);
        check_val({tag, "_nej"},     nickel_eject, 0);
        check_val({tag, "_dcnt"},    dime_count, 0);
        check_val({tag, "_ncnt"},    nickel_count, 0);
        check_val({tag, "_fault"},   fault, 0);
    endtask

    // asserted and released at negedges; outputs sampled 1 time unit into reset
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        m_dimes   = 0;
        m_nickels = 0;
    endtask

    task automatic restock(input int nd, input int nn);
        int n;
        n = (nd > nn) ? nd : nn;
        for (int i = 0; i < n; i++) begin
            load_dime   = (i < nd);
            load_nickel = (i < nn);
            @(negedge clock);
        end
        load_dime   = 1'b0;
        load_nickel = 1'b0;
        m_dimes   = sat_add(m_dimes, nd);
        m_nickels = sat_add(m_nickels, nn);
    endtask

    task automatic payout(input int amount, input int dmin, input int dmax, input bit load_on_ack);
        int  exp_seq[$];
        int  rem, dd, nn, idx, edges, exp_edges, wait_ctr, n_acks;
        bit  pending, got_done;
        rem = amount; dd = m_dimes; nn = m_nickels;
        while (rem >= 2 && dd > 0) begin exp_seq.push_back(2); rem -= 2; dd--; end
        while (rem >= 1 && nn > 0) begin exp_seq.push_back(1); rem -= 1; nn--; end
        idx = 0; n_acks = 0; pending = 0; got_done = 0; wait_ctr = 0;
        exp_edges = 3;

        check_val("ready_before_req", pif.req_ready, 1);
        pif.req_valid  = 1'b1;
        pif.req_amount = AMT_W'(amount);
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        pif.req_valid = 1'b0;

        while (!got_done && edges < 600) begin
            if (dime_eject || nickel_eject) begin
                check_val("eject_onehot", 32'(dime_eject & nickel_eject), 0);
                if (idx < exp_seq.size()) check_val("coin_kind", dime_eject ? 2 : 1, exp_seq[idx]);
                else                      check_val("extra_eject", idx, exp_seq.size());
                idx++;
                pending  = 1;
                wait_ctr = int'($urandom_range(dmax, dmin));
                exp_edges += 3 + wait_ctr;
            end
            if (pif.done) begin
                got_done = 1;
                check_val("done_no_eject", 32'(dime_eject | nickel_eject), 0);
                check_val("done_cycle", edges, exp_edges);
                check_val("short", pif.short, (rem != 0));
                check_val("short_amount", pif.short_amount, rem);
                check_val("ready_with_done", pif.req_ready, 1);
            end
            hopper_ack = 1'b0;
            load_dime  = 1'b0;
            if (pending) begin
                if (wait_ctr == 0) begin
                    hopper_ack = 1'b1;
                    load_dime  = load_on_ack;
                    pending    = 0;
                    n_acks++;
                end else begin
                    wait_ctr--;
                end
            end
            if (!got_done) begin
                @(posedge clock);
                edges++;
                @(negedge clock);
            end
        end
        hopper_ack = 1'b0;
        load_dime  = 1'b0;
        if (!got_done) check_val("done_timeout", 0, 1);
        check_val("eject_total", idx, exp_seq.size());

        m_dimes   = load_on_ack ? sat_add(dd, n_acks) : dd;
        m_nickels = nn;
        check_val("dime_count", dime_count, m_dimes);
        check_val("nickel_count", nickel_count, m_nickels);
    endtask

    task automatic request_until_eject(input int amount, output bit seen);
        seen = 0;
        pif.req_valid  = 1'b1;
        pif.req_amount = AMT_W'(amount);
        @(posedge clock);
        @(negedge clock);
        pif.req_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dime_eject || nickel_eject) seen = 1;
            else @(negedge clock);
        end
        if (!seen) check_val("eject_timeout", 0, 1);
    endtask

    initial begin
        bit seen;
        int n_done;
        pif.req_valid  = 1'b0;
        pif.req_amount = '0;

        #2;
        pulse_reset("reset");
        @(negedge clock);

        // zero request: done three edges after acceptance, no coins
        payout(0, 0, 0, 0);

        // 5 dimes / 5 nickels, pay 25c
        restock(5, 5);
        payout(5, 0, 2, 0);
        check_val("r038_dimes", dime_count, 3);
        check_val("r038_nickels", nickel_count, 4);

        // no dimes, 3 nickels, pay 20c -> 5c short
        pulse_reset("reset2");
        restock(0, 3);
        payout(4, 0, 1, 0);
        check_val("r039_nickels", nickel_count, 0);

        // stray ack while idle changes nothing
        restock(1, 1);
        hopper_ack = 1'b1;
        @(negedge clock);
        hopper_ack = 1'b0;
        @(negedge clock);
        check_val("stray_ack_dimes", dime_count, 1);
        check_val("stray_ack_nickels", nickel_count, 1);
        check_val("stray_ack_done", pif.done, 0);

        // load coincident with dime ack holds count, then saturation
        pulse_reset("reset3");
        restock(2, 0);
        payout(2, 0, 1, 1);
        check_val("load_on_ack_dimes", dime_count, 2);
        restock(260, 0);
        check_val("dime_saturate", dime_count, 255);
        restock(1, 0);
        check_val("dime_saturate_again", dime_count, 255);

        // randomized payouts
        pulse_reset("reset4");
        for (int t = 0; t < 25; t++) begin
            restock(int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
            payout(int'($urandom_range(20, 0)), 0, 3, 0);
        end

        // reset abandoned mid-payout
        restock(3, 3);
        request_until_eject(4, seen);
        pulse_reset("mid_reset");
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (pif.done) n_done++;
            @(negedge clock);
        end
        check_val("no_done_after_reset", n_done, 0);
        restock(1, 1);
        payout(3, 0, 2, 0);

`ifdef COIN_TIMEOUT_EN
        pulse_reset("reset5");
        restock(1, 0);
        request_until_eject(2, seen);
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        check_val("fault_early", fault, 0);
        @(posedge clock);
        @(negedge clock);
        check_val("fault_set", fault, 1);
        check_val("fault_ready", pif.req_ready, 0);
        hopper_ack = 1'b1;
        @(negedge clock);
        hopper_ack = 1'b0;
        repeat (5) @(negedge clock);
        check_val("fault_sticky", fault, 1);
        check_val("fault_ready_sticky", pif.req_ready, 0);
        pulse_reset("fault_reset");
`else
        // long ack wait: no timeout without the watchdog build
        restock(0, 1);
        payout(1, 40, 40, 0);
        check_val("no_fault", fault, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
